// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display controller.
// Provides the segment type, blank/zero patterns and the FSM state enum.
package hex_disp_pkg;

    // Active-low segment bundle, bit0=a .. bit6=g.
    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        COMMIT
    } state_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_ZERO  = 7'b1000000;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
// Ports: hex (nibble in), seg (active-low segments gfedcba out).
module hex7seg_dec
    import hex_disp_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit 7-segment display controller with valid/ready load,
// sequential MSB-first decode into a shadow register and atomic commit,
// optional leading-zero blanking and optional blinking.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready load handshake;
// in_data (nibble i -> digit i), in_lzb, in_blink captured on load;
// seg[i] active-low segments of digit i; done pulses on commit.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    input  logic                    in_lzb,
    input  logic                    in_blink,
    output seg_t [NUM_DIGITS-1:0]   seg,
    output logic                    done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [IW-1:0] IDX_TOP = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(BLINK_DIV - 1);

    state_t                  state;
    state_t                  state_nx;
    logic [4*NUM_DIGITS-1:0] data_q;
    logic                    lzb_q;
    logic                    blink_q;
    logic                    blink_act;
    logic                    nz;
    logic [IW-1:0]           idx;
    seg_t [NUM_DIGITS-1:0]   shadow;
    seg_t [NUM_DIGITS-1:0]   committed;
    logic [CW-1:0]           cnt;
    logic                    phase_off;

    logic [3:0] nib;
    seg_t       dec_seg;
    seg_t       dig_seg;
    logic       accept;
    logic       blank_lz;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && (state == IDLE);
    assign nib      = data_q[4*idx +: 4];

    hex7seg_dec u_dec (
        .hex (nib),
        .seg (dec_seg)
    );

    // A zero nibble is blanked only while no nonzero digit has been
    // seen above it; digit 0 always shows so a zero value reads "0".
    assign blank_lz = lzb_q && !nz && (nib == 4'h0) && (idx != '0);
    assign dig_seg  = blank_lz ? SEG_BLANK : dec_seg;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = DECODE;
            DECODE:  if (idx == '0) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            data_q    <= '0;
            lzb_q     <= 1'b0;
            blink_q   <= 1'b0;
            blink_act <= 1'b0;
            nz        <= 1'b0;
            idx       <= '0;
            done      <= 1'b0;
            shadow    <= {NUM_DIGITS{SEG_ZERO}};
            committed <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            state <= state_nx;
            done  <= (state == COMMIT);
            if (accept) begin
                data_q  <= in_data;
                lzb_q   <= in_lzb;
                blink_q <= in_blink;
                idx     <= IDX_TOP;
                nz      <= 1'b0;
            end
            if (state == DECODE) begin
                shadow[idx] <= dig_seg;
                nz          <= nz | (nib != 4'h0);
                idx         <= idx - 1'b1;
            end
            // All digits switch on the same edge, so no mixed frame.
            if (state == COMMIT) begin
                committed <= shadow;
                blink_act <= blink_q;
            end
        end
    end

    // Free-running blink timebase; loads never disturb it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            phase_off <= 1'b0;
        end else if (cnt == CNT_TOP) begin
            cnt       <= '0;
            phase_off <= ~phase_off;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        seg = committed;
        if (blink_act && phase_off) begin
            seg = {NUM_DIGITS{SEG_BLANK}};
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomized self-checking bench for hex_display_ctrl.
// Compares every cycle against a transaction-level display model.
module tb_hex_display_ctrl;

    localparam int ND = 8;
    localparam int BD = 4;

    localparam logic [6:0] TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4*ND-1:0] in_data  = '0;
    logic            in_lzb   = 1'b0;
    logic            in_blink = 1'b0;
    logic [ND-1:0][6:0] seg;
    logic            done;

    always #5 clk = ~clk;

    hex_display_ctrl #(
        .NUM_DIGITS (ND),
        .BLINK_DIV  (BD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_lzb   (in_lzb),
        .in_blink (in_blink),
        .seg      (seg),
        .done     (done)
    );

    int checks = 0;
    int errors = 0;

    // Model state: cycles left in a transaction, edges since reset,
    // pending load, and what the display should currently hold.
    int          left = 0;
    int          n    = 0;
    logic [31:0] pend_v;
    logic        pend_l;
    logic        pend_b;
    logic [55:0] m_com;
    logic        m_blk  = 1'b0;
    logic        m_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [55:0] disp(input logic [31:0] v,
                                         input logic lzb);
        logic [55:0] r;
        logic [31:0] upper;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            upper = v >> (4 * i);
            if (lzb && i != 0 && upper == 0)
                r[i*7 +: 7] = 7'b1111111;
            else
                r[i*7 +: 7] = TBL[upper[3:0]];
        end
        return r;
    endfunction

    // One clock: predict the edge's effect, then compare at negedge.
    task automatic step();
        logic acc;
        logic rs;
        logic off;
        acc = rst_n && in_valid && (left == 0);
        rs  = !rst_n;
        @(negedge clk);
        m_done = 1'b0;
        if (rs) begin
            left  = 0;
            n     = 0;
            m_com = {ND{7'b1000000}};
            m_blk = 1'b0;
        end else begin
            n++;
            if (acc) begin
                left   = ND + 1;
                pend_v = in_data;
                pend_l = in_lzb;
                pend_b = in_blink;
            end else if (left > 0) begin
                left--;
                if (left == 0) begin
                    m_com  = disp(pend_v, pend_l);
                    m_blk  = pend_b;
                    m_done = 1'b1;
                end
            end
        end
        off = ((n / BD) % 2) == 1;
        chk("in_ready", 64'(in_ready), 64'(left == 0));
        chk("done", 64'(done), 64'(m_done));
        chk("seg", 64'(seg), 64'((m_blk && off) ? {56{1'b1}} : m_com));
    endtask

    task automatic load(input logic [31:0] v, input logic l,
                        input logic b);
        while (left != 0) step();
        in_data  = v;
        in_lzb   = l;
        in_blink = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic settle();
        while (left != 0) step();
        step();
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        v = $urandom;
        for (int i = 0; i < ND; i++)
            if ($urandom_range(0, 1) == 0) v[i*4 +: 4] = 4'h0;
        return v;
    endfunction

    initial begin
        m_com = {ND{7'b1000000}};
        pend_v = '0;
        pend_l = 1'b0;
        pend_b = 1'b0;

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        load(32'h0123ABCD, 1'b0, 1'b0);
        settle();
        chk("basic_seg", 64'(seg), 64'({7'b1000000, 7'b1111001,
            7'b0100100, 7'b0110000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001}));

        load(32'h00000A50, 1'b1, 1'b0);
        settle();
        chk("lzb_a50", 64'(seg), 64'({{5{7'b1111111}}, 7'b0001000,
            7'b0010010, 7'b1000000}));

        load(32'h00000000, 1'b1, 1'b0);
        settle();
        chk("lzb_zero", 64'(seg), 64'({{7{7'b1111111}}, 7'b1000000}));

        load(32'h11111111, 1'b0, 1'b0);
        step();
        step();
        in_data  = 32'h22222222;
        in_valid = 1'b1;
        step();
        step();
        step();
        in_valid = 1'b0;
        settle();
        chk("busy_seg", 64'(seg), 64'({ND{7'b1111001}}));

        load(32'h00000007, 1'b0, 1'b1);
        repeat (20) step();
        load(32'h00000007, 1'b0, 1'b0);
        settle();
        repeat (10) step();

        in_data  = 32'h89ABCDEF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        load(32'h00FEDC00, 1'b1, 1'b0);
        settle();

        for (int k = 0; k < 80; k++) begin
            repeat ($urandom_range(0, 2)) step();
            load(rnd_val(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) begin
                in_data  = $urandom;
                in_valid = 1'b1;
                repeat ($urandom_range(1, 4)) step();
                in_valid = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 8)) step();
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            repeat ($urandom_range(0, 12)) step();
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Parametrised successor to the fixed switch-to-HEX display path; drives NUM_DIGITS active-low 7-segment digits from a loaded hex value.
- Adds a valid/ready load handshake, sequential per-digit decode with an atomic commit, optional leading-zero blanking, and optional blinking.
- Sits between the CPU/IO register (or SW sampler) and the HEX0..HEX(n-1) pins in top.

Parameters:
NUM_DIGITS, 8, number of 7-segment digits driven; data width is 4*NUM_DIGITS.
BLINK_DIV, 25000000, clock cycles per blink half-period (0.5 s at 50 MHz); must be >= 2.

Ports:
clk  input  1  system clock (CLOCK_50 domain)
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  load request
in_ready  output  1  high only in IDLE; a load is accepted when in_valid && in_ready at a rising edge
in_data  input  4*NUM_DIGITS  hex value; nibble i maps to digit i
in_lzb  input  1  leading-zero blank enable, captured with in_data
in_blink  input  1  blink enable, captured with in_data
seg  output  [NUM_DIGITS][7]  active-low segments; seg[i] is digit i; bit0=a .. bit6=g
done  output  1  one-cycle pulse, coincident with the first cycle new segments are visible

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low via rst_n, sampled on the rising edge of clk.
- Reset values:
  - state=IDLE; in_ready=1; done=0.
  - Committed and shadow digits = 7'b1000000 ("0"); lzb=0; blink=0.
  - Blink counter=0; blink phase=ON.
- FSM states and transitions:
  - IDLE -> DECODE when the load is accepted. in_data, in_lzb and in_blink are latched, and idx=NUM_DIGITS-1.
  - DECODE: each cycle decodes latched nibble idx into shadow[idx], then decrements idx. Order is MSB first. After idx=0 is decoded -> COMMIT.
  - COMMIT: shadow is copied to the committed register, the latched blink flag is copied to the active blink flag, done=1 for one cycle -> IDLE.
- Latency:
  - Acceptance edge E0. New seg values and done appear after edge E0+NUM_DIGITS+1.
  - in_ready is low for NUM_DIGITS+1 cycles and is high again in the same cycle done is high.
- Atomic update: seg never shows a mix of old and new digits.
- Leading-zero blanking (lzb=1):
  - A running flag nz clears at DECODE entry and sets on the first nonzero nibble.
  - A zero nibble with nz=0 and idx!=0 decodes to blank 7'b1111111.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Decode table (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blink:
  - Counter runs 0..BLINK_DIV-1 continuously from reset. At wrap it returns to 0 and the phase toggles.
  - seg = (active blink && phase==OFF) ? all 7'b1111111 : committed.
  - seg is a function of registers only; no combinational path from inputs.
  - A commit does not reset the counter or the phase.
- in_valid while busy: ignored, nothing captured; the producer must hold the request until in_ready.
- Reset mid-DECODE or mid-COMMIT:
  - Returns to IDLE; shadow and latched values are discarded.
  - seg returns to all "0"; done stays 0.
- A load accepted in the cycle immediately after COMMIT is legal (back-to-back loads).

Decomposition:
- Shared package hex_disp_pkg holds:
  - SEG_BLANK=7'b1111111 and SEG_ZERO=7'b1000000;
  - the state enum {IDLE, DECODE, COMMIT};
  - the seg_t typedef (logic [6:0]).
- One natural sub-module: hex7seg_dec, a combinational 4-bit to active-low 7-segment decoder. It is instantiated once and shared across digits through idx.

Test Plan:
All scenarios use NUM_DIGITS=8, BLINK_DIV=4.
1. Reset: hold rst_n=0 for 2 cycles, release -> every seg[i]=1000000, in_ready=1, done=0.
2. Basic load: load 0x0123ABCD with lzb=0 and blink=0 at E0 -> in_ready low for 9 cycles. After E0+9: done=1 for one cycle, seg[0]=0100001, seg[1]=1000110, seg[2]=0000011, seg[3]=0001000, seg[4]=0110000, seg[5]=0100100, seg[6]=1111001, seg[7]=1000000. No intermediate mixed values at any point.
3. Leading-zero blanking:
   - Load 0x00000A50 with lzb=1 -> seg[7..3]=1111111, seg[2]=0001000, seg[1]=0010010, seg[0]=1000000.
   - Load 0x00000000 with lzb=1 -> only seg[0]=1000000; all others blank.
4. Busy collision: load 0x11111111, then assert in_valid with 0x22222222 two cycles later and drop it before in_ready returns -> final seg shows all 1111001, with exactly one done pulse.
5. Blink: load 0x00000007 with blink=1 -> after commit, seg alternates between committed (seg[0]=1111000) and all-blank, with 4-cycle half-periods. A reload with blink=0 gives steady output after its commit.
6. Reset mid-decode: assert rst_n=0 at E0+4 of a load -> next cycle state is IDLE, seg all 1000000, no done pulse. A subsequent load completes normally.
